axi_portal_sched: RTL
=====================

# axi_portal_sched

Request scheduler for the MAXI slave portal. It shares one sequential portal access port between the AXI read-address (AR) stream and the write-address/write-data (AW/W) streams, arbitrating round-robin at burst granularity. It expands each burst into per-beat accesses carrying a last flag, and issues a write-done token (B channel) after the final write beat. It sits between the AR/AW/W request FIFOs and the portal register/user datapath.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, beat data width
- ID_W, 6, transaction id width
- LEN_W, 4, burst length field width; beats = len+1

Ports:
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- ar__ENA  in  1  read request valid
- ar$addr / ar$id / ar$len  in  ADDR_W / ID_W / LEN_W  read burst descriptor
- ar__RDY  out  1  read request accepted this cycle when ar__ENA high
- aw__ENA  in  1  write request valid
- aw$addr / aw$id / aw$len  in  ADDR_W / ID_W / LEN_W  write burst descriptor
- aw__RDY  out  1  write request accepted when aw__ENA high
- w__ENA  in  1  write beat valid
- w$data  in  DATA_W  write beat data
- w__RDY  out  1  write beat consumed
- acc__ENA  out  1  portal access valid
- acc__RDY  in  1  portal accepts access
- acc$write  out  1  1 = write, 0 = read
- acc$addr / acc$data / acc$id  out  ADDR_W / DATA_W / ID_W  access fields; acc$data is 0 on reads
- acc$last  out  1  final beat of burst
- bdone__ENA  out  1  write response valid
- bdone$id  out  ID_W  id of completed write
- bdone__RDY  in  1  response consumer ready

## Operation
- States: IDLE, RBURST, WBURST, WRESP.
- IDLE: ar__RDY = ar__ENA && (!aw__ENA || prio==READ); aw__RDY is the mirror. At most one is granted per cycle.
  - Read grant: latch addr, id, len into cur, beat count = len, then go to RBURST.
  - Write grant: latch the same fields, then go to WBURST.
  - prio toggles to the other side after every grant.
- RBURST:
  - acc__ENA = 1, acc$write = 0, acc$last = (count==0).
  - On acc__RDY: decrement count and advance addr (see Configuration).
  - On acc__RDY with last: go to IDLE.
- WBURST:
  - acc__ENA = w__ENA, w__RDY = acc__RDY, acc$write = 1, acc$data = w$data.
  - A beat transfers only when w__ENA && acc__RDY. Count and address update on each transfer.
  - A transferred last beat goes to WRESP.
- WRESP: bdone__ENA = 1, bdone$id = cur id. On bdone__RDY, go to IDLE.
- Any w beats arriving outside WBURST are not consumed (w__RDY = 0).
- Count uses LEN_W bits. Address addition is modulo 2^ADDR_W, so it wraps silently.
- Reset, whether at start-up or mid-burst:
  - state = IDLE, prio = READ, count/addr/id = 0.
  - All outputs read 0 while nRST is low, including ar__RDY and aw__RDY, which are forced low.
  - Any in-flight burst is abandoned and no bdone is issued for it.

## Timing
- A request accepted in cycle N produces its first acc__ENA in cycle N+1.
- With acc__RDY held high, a read burst takes len+1 consecutive cycles. IDLE follows, so there is a minimum 1-cycle gap between bursts.
- Write: bdone__ENA asserts the cycle after the last beat transfers and stays asserted until bdone__RDY is sampled high.
- acc__ENA and acc fields are combinational from registered state, plus w$data/w__ENA in WBURST. There is no other input-to-output combinational path.
- Simultaneous ar__ENA and aw__ENA in IDLE: prio decides. Strict alternation applies under continuous contention.

## Configuration
- AXI_PORTAL_SCHED_INCR_EN defined: acc$addr advances by DATA_W/8 (4) per transferred beat, starting from the latched addr.
- Not defined: acc$addr holds the latched addr for every beat of the burst (fixed-address FIFO portal). This is the default build.

## Structure
- Shared package axi_portal_sched_pkg contains:
  - state enum
  - PRIO_READ/PRIO_WRITE constants
  - ADDR_STEP constant (DATA_W/8)
  - packed burst descriptor struct {addr, id, len}
- Sub-module portal_beat_gen holds the descriptor register, beat counter, address generator and last flag, with load/step inputs. The top holds the FSM and the round-robin bit.

## Test plan
- Single read: ar addr=0x40 id=5 len=3, acc__RDY=1 -> 4 read accesses in cycles N+1..N+4, id 5, last only on the 4th. Addr is 0x40,0x44,0x48,0x4C with INCR_EN and 0x40 ×4 without.
- Write with stalls: aw len=1 id=9; beats 0xA5A5_0001 and 0xA5A5_0002 with w__ENA gap and acc__RDY low for 2 cycles -> exactly 2 write accesses in order. bdone id=9 asserts the cycle after beat 2 and holds until bdone__RDY.
- Contention: ar__ENA and aw__ENA both held high from reset -> read granted first, then strict alternation R,W,R,W. Every write is followed by a bdone before the next grant.
- Backpressure: bdone__RDY low for 5 cycles -> ar__RDY and aw__RDY stay 0 and no acc__ENA is issued. Resume occurs one cycle after bdone__RDY rises.
- Reset mid-burst: nRST low during beat 2 of len=7 read -> all outputs 0 immediately. After release, state is IDLE, a new read is accepted, and no bdone is issued for the aborted burst.
- Wrap: ar addr=0xFFFF_FFFC len=1 with INCR_EN -> second beat addr 0x0000_0000.

Source files
------------

// File: rtl/axi_portal_sched_pkg.sv
// axi_portal_sched_pkg: shared FSM states, round-robin constants, beat address step and burst descriptor
package axi_portal_sched_pkg;
    typedef enum logic [1:0] {IDLE, RBURST, WBURST, WRESP} state_t;
    localparam logic PRIO_READ = 1'b0;
    localparam logic PRIO_WRITE = 1'b1;
    localparam int DESC_ADDR_W = 32;
    localparam int DESC_DATA_W = 32;
    localparam int DESC_ID_W = 6;
    localparam int DESC_LEN_W = 4;
    localparam int ADDR_STEP = DESC_DATA_W / 8;
    typedef struct packed {
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_ID_W-1:0] id;
        logic [DESC_LEN_W-1:0] len;
    } desc_t;
endpackage

// File: rtl/portal_beat_gen.sv
// portal_beat_gen: descriptor register, beat counter, beat address (+STEP when AXI_PORTAL_SCHED_INCR_EN) and last flag
module portal_beat_gen
    import axi_portal_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ID_W = 6,
    parameter int LEN_W = 4,
    parameter int STEP = ADDR_STEP
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ID_W-1:0]   ld_id,
    input  logic [LEN_W-1:0]  ld_len,
    output logic [ADDR_W-1:0] addr,
    output logic [ID_W-1:0]   id,
    output logic              last
);
`ifdef AXI_PORTAL_SCHED_INCR_EN
    localparam logic INCR = 1'b1;
`else
    localparam logic INCR = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] INC = INCR ? ADDR_W'(STEP) : '0;
    logic [LEN_W-1:0] cnt;
    assign last = cnt == '0;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr <= '0;
            id <= '0;
            cnt <= '0;
        end else if (load) begin
            addr <= ld_addr;
            id <= ld_id;
            cnt <= ld_len;
        end else if (step) begin
            addr <= addr + INC;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/axi_portal_sched.sv
// axi_portal_sched: round-robin AR vs AW/W burst scheduler onto one portal access port with B done tokens; AXI_PORTAL_SCHED_INCR_EN enables incrementing beat addresses
module axi_portal_sched
    import axi_portal_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W = 6,
    parameter int LEN_W = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ar__ENA,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [ID_W-1:0]   ar_id,
    input  logic [LEN_W-1:0]  ar_len,
    output logic              ar__RDY,
    input  logic              aw__ENA,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [ID_W-1:0]   aw_id,
    input  logic [LEN_W-1:0]  aw_len,
    output logic              aw__RDY,
    input  logic              w__ENA,
    input  logic [DATA_W-1:0] w_data,
    output logic              w__RDY,
    output logic              acc__ENA,
    input  logic              acc__RDY,
    output logic              acc_write,
    output logic [ADDR_W-1:0] acc_addr,
    output logic [DATA_W-1:0] acc_data,
    output logic [ID_W-1:0]   acc_id,
    output logic              acc_last,
    output logic              bdone__ENA,
    output logic [ID_W-1:0]   bdone_id,
    input  logic              bdone__RDY
);
    state_t state;
    logic prio;
    logic [ADDR_W-1:0] cur_addr;
    logic [ID_W-1:0] cur_id;
    logic cur_last;
    logic idle, rb, wb, busy, xfer;
    assign idle = nRST && state == IDLE;
    assign rb = state == RBURST;
    assign wb = state == WBURST;
    assign busy = rb || wb;
    assign ar__RDY = idle && ar__ENA && (!aw__ENA || prio == PRIO_READ);
    assign aw__RDY = idle && aw__ENA && (!ar__ENA || prio == PRIO_WRITE);
    assign w__RDY = wb && acc__RDY;
    assign acc__ENA = rb || (wb && w__ENA);
    assign acc_write = wb;
    assign acc_addr = busy ? cur_addr : '0;
    assign acc_data = wb ? w_data : '0;
    assign acc_id = busy ? cur_id : '0;
    assign acc_last = busy && cur_last;
    assign bdone__ENA = state == WRESP;
    assign bdone_id = bdone__ENA ? cur_id : '0;
    assign xfer = acc__ENA && acc__RDY;
    portal_beat_gen #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W), .STEP(DATA_W / 8)) u_beat (
        .CLK(CLK),
        .nRST(nRST),
        .load(ar__RDY || aw__RDY),
        .step(xfer),
        .ld_addr(ar__RDY ? ar_addr : aw_addr),
        .ld_id(ar__RDY ? ar_id : aw_id),
        .ld_len(ar__RDY ? ar_len : aw_len),
        .addr(cur_addr),
        .id(cur_id),
        .last(cur_last)
    );
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            prio <= PRIO_READ;
        end else begin
            case (state)
                IDLE: begin
                    if (ar__RDY) begin
                        state <= RBURST;
                        prio <= PRIO_WRITE;
                    end else if (aw__RDY) begin
                        state <= WBURST;
                        prio <= PRIO_READ;
                    end
                end
                RBURST: if (xfer && cur_last) state <= IDLE;
                WBURST: if (xfer && cur_last) state <= WRESP;
                default: if (bdone__RDY) state <= IDLE;
            endcase
        end
    end
endmodule
